// File: rtl/bp_me_pkg.sv
// Shared types for the BedRock-lite IO arbiter slice.
// Message layout, arbiter states and config helpers.
package bp_me_pkg;

  typedef enum logic [1:0] {
    e_bp_default_cfg = 2'd0,
    e_bp_unicore_cfg = 2'd1
  } bp_params_e;

  typedef enum logic [1:0] {
    e_idle = 2'd0,
    e_send = 2'd1,
    e_resp = 2'd2
  } bp_lite_arb_state_e;

  typedef enum logic [3:0] {
    e_bedrock_mem_rd    = 4'd0,
    e_bedrock_mem_wr    = 4'd1,
    e_bedrock_mem_uc_rd = 4'd2,
    e_bedrock_mem_uc_wr = 4'd3
  } bp_bedrock_mem_type_e;

  localparam int paddr_width_lp = 40;
  localparam int data_width_lp  = 64;

  typedef struct packed {
    bp_bedrock_mem_type_e        msg_type;
    logic [2:0]                  size;
    logic [paddr_width_lp-1:0]   addr;
    logic [data_width_lp-1:0]    data;
  } bp_bedrock_mem_msg_s;

  // Both supported configs share one message layout.
  function automatic int cce_mem_msg_width(bp_params_e cfg);
    return (cfg == e_bp_default_cfg)
      ? $bits(bp_bedrock_mem_msg_s)
      : $bits(bp_bedrock_mem_msg_s);
  endfunction

endpackage

// File: rtl/bp_lite_rr_picker.sv
// Round-robin picker: first requester at or above rr_ptr_i,
// wrapping modulo num_clients_p.
module bp_lite_rr_picker
  import bp_me_pkg::*;
#(
  parameter int num_clients_p = 2,
  parameter int lg_clients_lp =
    (num_clients_p > 1) ? $clog2(num_clients_p) : 1
) (
  input  logic [num_clients_p-1:0] req_i,
  input  logic [lg_clients_lp-1:0] rr_ptr_i,
  output logic [num_clients_p-1:0] grant_oh_o,
  output logic [lg_clients_lp-1:0] grant_idx_o,
  output logic                     any_v_o
);

  int idx;

  // Scan downward in priority so the nearest requester wins last.
  always_comb begin
    grant_idx_o = '0;
    idx         = 0;
    for (int k = num_clients_p - 1; k >= 0; k--) begin
      idx = (int'(rr_ptr_i) + k) % num_clients_p;
      if (req_i[idx]) begin
        grant_idx_o = lg_clients_lp'(idx);
      end
    end
  end

  assign any_v_o    = |req_i;
  assign grant_oh_o = any_v_o
    ? (num_clients_p'(1) << grant_idx_o)
    : '0;

endmodule

// File: rtl/bp_lite_io_cmd_arbiter.sv
// Shares one BedRock-lite IO port among several requesters,
// one transaction outstanding, round-robin grant.
module bp_lite_io_cmd_arbiter
  import bp_me_pkg::*;
#(
  parameter bp_params_e bp_params_p = e_bp_default_cfg,
  parameter int num_clients_p = 2,
  parameter int lg_clients_lp =
    (num_clients_p > 1) ? $clog2(num_clients_p) : 1,
  localparam int cce_mem_msg_width_lp =
    cce_mem_msg_width(bp_params_p)
) (
  input  logic clk_i,
  input  logic reset_i,

  input  logic [num_clients_p*cce_mem_msg_width_lp-1:0]
               client_io_cmd_i,
  input  logic [num_clients_p-1:0] client_io_cmd_v_i,
  output logic [num_clients_p-1:0] client_io_cmd_yumi_o,

  output logic [cce_mem_msg_width_lp-1:0] client_io_resp_o,
  output logic [num_clients_p-1:0] client_io_resp_v_o,
  input  logic [num_clients_p-1:0] client_io_resp_ready_i,

  output logic [cce_mem_msg_width_lp-1:0] io_cmd_o,
  output logic io_cmd_v_o,
  input  logic io_cmd_yumi_i,

  input  logic [cce_mem_msg_width_lp-1:0] io_resp_i,
  input  logic io_resp_v_i,
  output logic io_resp_ready_o,

  output logic busy_o,
  output logic [lg_clients_lp-1:0] owner_o
);

  localparam int w_lp = cce_mem_msg_width_lp;

  bp_lite_arb_state_e state_r, state_n;
  logic [lg_clients_lp-1:0] owner_r, owner_n;
  logic [lg_clients_lp-1:0] rr_ptr_r, rr_ptr_n;

  logic [w_lp-1:0] cmd_arr [num_clients_p];
  logic [num_clients_p-1:0] pick_oh;
  logic [lg_clients_lp-1:0] pick_idx;
  logic pick_v;
  logic own_v;

  for (genvar i = 0; i < num_clients_p; i++) begin : g_cmd
    assign cmd_arr[i] = client_io_cmd_i[i*w_lp +: w_lp];
  end

  bp_lite_rr_picker #(
    .num_clients_p (num_clients_p),
    .lg_clients_lp (lg_clients_lp)
  ) picker (
    .req_i       (client_io_cmd_v_i),
    .rr_ptr_i    (rr_ptr_r),
    .grant_oh_o  (pick_oh),
    .grant_idx_o (pick_idx),
    .any_v_o     (pick_v)
  );

  assign own_v = client_io_cmd_v_i[owner_r];

  // State, owner and priority pointer registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r  <= e_idle;
      owner_r  <= '0;
      rr_ptr_r <= '0;
    end else begin
      state_r  <= state_n;
      owner_r  <= owner_n;
      rr_ptr_r <= rr_ptr_n;
    end
  end

  // Next state plus combinational command/response steering.
  always_comb begin
    state_n              = state_r;
    owner_n              = owner_r;
    rr_ptr_n             = rr_ptr_r;
    io_cmd_o             = '0;
    io_cmd_v_o           = 1'b0;
    client_io_cmd_yumi_o = '0;
    client_io_resp_v_o   = '0;
    io_resp_ready_o      = 1'b0;
    unique case (state_r)
      e_idle: begin
        if (pick_v) begin
          io_cmd_o             = cmd_arr[pick_idx];
          io_cmd_v_o           = 1'b1;
          owner_n              = pick_idx;
          client_io_cmd_yumi_o =
            pick_oh & {num_clients_p{io_cmd_yumi_i}};
          state_n = io_cmd_yumi_i ? e_resp : e_send;
        end
      end
      e_send: begin
        io_cmd_o   = cmd_arr[owner_r];
        io_cmd_v_o = own_v;
        if (!own_v) begin
          state_n = e_idle;
        end else if (io_cmd_yumi_i) begin
          client_io_cmd_yumi_o[owner_r] = 1'b1;
          state_n = e_resp;
        end
      end
      e_resp: begin
        client_io_resp_v_o[owner_r] = io_resp_v_i;
        io_resp_ready_o = client_io_resp_ready_i[owner_r];
        if (io_resp_v_i && io_resp_ready_o) begin
          rr_ptr_n =
            (owner_r == lg_clients_lp'(num_clients_p - 1))
            ? '0 : owner_r + 1'b1;
          state_n = e_idle;
        end
      end
      default: state_n = e_idle;
    endcase
  end

  assign client_io_resp_o = io_resp_i;
  assign busy_o           = (state_r != e_idle);
  assign owner_o          = owner_r;

endmodule

// File: tb/tb_bp_lite_io_cmd_arbiter.sv
// Directed bench for the round-robin IO command arbiter,
// two clients, hand-computed expectations.
module tb_bp_lite_io_cmd_arbiter;
  import bp_me_pkg::*;

  localparam int n_lp = 2;
  localparam int w_lp = $bits(bp_bedrock_mem_msg_s);

  logic clk_i = 1'b0;
  logic reset_i;
  logic [n_lp*w_lp-1:0] client_io_cmd_i;
  logic [n_lp-1:0] client_io_cmd_v_i;
  logic [n_lp-1:0] client_io_cmd_yumi_o;
  logic [w_lp-1:0] client_io_resp_o;
  logic [n_lp-1:0] client_io_resp_v_o;
  logic [n_lp-1:0] client_io_resp_ready_i;
  logic [w_lp-1:0] io_cmd_o;
  logic io_cmd_v_o;
  logic io_cmd_yumi_i;
  logic [w_lp-1:0] io_resp_i;
  logic io_resp_v_i;
  logic io_resp_ready_o;
  logic busy_o;
  logic owner_o;

  int checks = 0;
  int errors = 0;

  bp_bedrock_mem_msg_s cmd0, cmd1, resp;

  always #5 clk_i = ~clk_i;

  bp_lite_io_cmd_arbiter #(
    .num_clients_p (n_lp)
  ) dut (
    .clk_i                  (clk_i),
    .reset_i                (reset_i),
    .client_io_cmd_i        (client_io_cmd_i),
    .client_io_cmd_v_i      (client_io_cmd_v_i),
    .client_io_cmd_yumi_o   (client_io_cmd_yumi_o),
    .client_io_resp_o       (client_io_resp_o),
    .client_io_resp_v_o     (client_io_resp_v_o),
    .client_io_resp_ready_i (client_io_resp_ready_i),
    .io_cmd_o               (io_cmd_o),
    .io_cmd_v_o             (io_cmd_v_o),
    .io_cmd_yumi_i          (io_cmd_yumi_i),
    .io_resp_i              (io_resp_i),
    .io_resp_v_i            (io_resp_v_i),
    .io_resp_ready_o        (io_resp_ready_o),
    .busy_o                 (busy_o),
    .owner_o                (owner_o)
  );

  task automatic chk(input string tag,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk_i);
    #1;
  endtask

  function automatic bp_bedrock_mem_msg_s mk(
    input bp_bedrock_mem_type_e t,
    input logic [39:0] a,
    input logic [63:0] d);
    bp_bedrock_mem_msg_s m;
    m.msg_type = t;
    m.size     = 3'd2;
    m.addr     = a;
    m.data     = d;
    return m;
  endfunction

  initial begin
    cmd0 = mk(e_bedrock_mem_uc_wr, 40'h2000, 64'h1111);
    cmd1 = mk(e_bedrock_mem_uc_rd, 40'h1000, 64'h0);
    resp = mk(e_bedrock_mem_uc_rd, 40'h1000, 64'hDEADBEEF);
    client_io_cmd_i        = {cmd1, cmd0};
    client_io_cmd_v_i      = '0;
    client_io_resp_ready_i = '0;
    io_cmd_yumi_i          = 1'b0;
    io_resp_i              = resp;
    io_resp_v_i            = 1'b0;
    reset_i                = 1'b1;

    step();
    chk("rst_yumi", 128'(client_io_cmd_yumi_o), 0);
    chk("rst_cmd_v", 128'(io_cmd_v_o), 0);
    chk("rst_resp_v", 128'(client_io_resp_v_o), 0);
    chk("rst_ready", 128'(io_resp_ready_o), 0);
    chk("rst_busy", 128'(busy_o), 0);
    reset_i = 1'b0;
    step();
    chk("post_rst_cmd_v", 128'(io_cmd_v_o), 0);
    chk("post_rst_owner", 128'(owner_o), 0);
    chk("post_rst_ptr", 128'(dut.rr_ptr_r), 0);

    // single client 1 read
    client_io_cmd_v_i = 2'b10;
    io_cmd_yumi_i     = 1'b1;
    #1;
    chk("t1_yumi", 128'(client_io_cmd_yumi_o), 2);
    chk("t1_cmd_v", 128'(io_cmd_v_o), 1);
    chk("t1_cmd", 128'(io_cmd_o), 128'(cmd1));
    step();
    client_io_cmd_v_i      = '0;
    io_cmd_yumi_i          = 1'b0;
    io_resp_v_i            = 1'b1;
    client_io_resp_ready_i = 2'b11;
    #1;
    chk("t1_resp_v", 128'(client_io_resp_v_o), 2);
    chk("t1_ready", 128'(io_resp_ready_o), 1);
    chk("t1_resp", 128'(client_io_resp_o), 128'(resp));
    step();
    io_resp_v_i = 1'b0;
    #1;
    chk("t1_busy", 128'(busy_o), 0);
    chk("t1_ptr", 128'(dut.rr_ptr_r), 0);
    chk("t1_owner", 128'(owner_o), 1);

    // contention, both valid
    client_io_cmd_v_i = 2'b11;
    io_cmd_yumi_i     = 1'b1;
    io_resp_v_i       = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("t2_grant", 128'(client_io_cmd_yumi_o),
          128'(1 << (i % 2)));
      step();
      #1;
      chk("t2_resp_v", 128'(client_io_resp_v_o),
          128'(1 << (i % 2)));
      chk("t2_no_yumi", 128'(client_io_cmd_yumi_o), 0);
      step();
    end

    // endpoint backpressure
    client_io_cmd_v_i = 2'b01;
    io_cmd_yumi_i     = 1'b0;
    io_resp_v_i       = 1'b0;
    #1;
    chk("t3_cmd_v", 128'(io_cmd_v_o), 1);
    chk("t3_yumi0", 128'(client_io_cmd_yumi_o), 0);
    step();
    client_io_cmd_v_i = 2'b11;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t3_owner", 128'(owner_o), 0);
      chk("t3_cmd", 128'(io_cmd_o), 128'(cmd0));
      chk("t3_no_yumi", 128'(client_io_cmd_yumi_o), 0);
      step();
    end
    io_cmd_yumi_i = 1'b1;
    #1;
    chk("t3_yumi", 128'(client_io_cmd_yumi_o), 1);
    step();

    // response backpressure, client 1 still waiting
    client_io_cmd_v_i      = 2'b10;
    io_resp_v_i            = 1'b1;
    client_io_resp_ready_i = 2'b10;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t4_ready", 128'(io_resp_ready_o), 0);
      chk("t4_resp_v", 128'(client_io_resp_v_o), 1);
      chk("t4_no_grant", 128'(client_io_cmd_yumi_o), 0);
      chk("t4_busy", 128'(busy_o), 1);
      step();
    end
    client_io_resp_ready_i = 2'b11;
    #1;
    chk("t4_ready_go", 128'(io_resp_ready_o), 1);
    step();
    client_io_cmd_v_i = '0;
    io_cmd_yumi_i     = 1'b0;
    #1;
    chk("t4_ptr", 128'(dut.rr_ptr_r), 1);

    // stray response while idle
    chk("t5_ready", 128'(io_resp_ready_o), 0);
    chk("t5_resp_v", 128'(client_io_resp_v_o), 0);
    step();
    chk("t5_busy", 128'(busy_o), 0);

    // reset during response phase
    io_resp_v_i       = 1'b0;
    client_io_cmd_v_i = 2'b10;
    io_cmd_yumi_i     = 1'b1;
    #1;
    chk("t6_yumi", 128'(client_io_cmd_yumi_o), 2);
    step();
    chk("t6_busy_resp", 128'(busy_o), 1);
    reset_i           = 1'b1;
    client_io_cmd_v_i = '0;
    io_cmd_yumi_i     = 1'b0;
    step();
    reset_i = 1'b0;
    #1;
    chk("t6_state", 128'(dut.state_r), 128'(e_idle));
    chk("t6_busy", 128'(busy_o), 0);
    chk("t6_ptr", 128'(dut.rr_ptr_r), 0);
    client_io_cmd_v_i = 2'b10;
    io_cmd_yumi_i     = 1'b1;
    #1;
    chk("t6_regrant", 128'(client_io_cmd_yumi_o), 2);
    step();
    client_io_cmd_v_i = '0;
    io_cmd_yumi_i     = 1'b0;
    io_resp_v_i       = 1'b1;
    #1;
    chk("t6_resp_v", 128'(client_io_resp_v_o), 2);
    step();
    io_resp_v_i = 1'b0;
    #1;
    chk("t6_ptr_end", 128'(dut.rr_ptr_r), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/bp_lite_io_cmd_arbiter.md
# bp_lite_io_cmd_arbiter

Shares one BedRock-lite IO port (io_cmd/io_resp, cce mem message format) among `num_clients_p` requesters, typically several AXI-lite-to-BP-lite client bridges. Arbitration is round-robin. Exactly one transaction is outstanding at a time, and the response is routed back to the requester that issued the command. The block sits between the bridges and the downstream IO/memory endpoint.

## Interface
Parameters:
- `bp_params_p`, default `e_bp_default_cfg`: processor config; supplies `cce_mem_msg_width_lp`.
- `num_clients_p`, default 2: number of requesters, range 2..8.
- `lg_clients_lp`, default `` `BSG_SAFE_CLOG2(num_clients_p) ``: index width (derived).

Ports:
- `clk_i` in 1: clock.
- `reset_i` in 1: synchronous, active-high reset.
- `client_io_cmd_i` in `num_clients_p*cce_mem_msg_width_lp`: per-client command message, client i at slice i.
- `client_io_cmd_v_i` in `num_clients_p`: per-client command valid.
- `client_io_cmd_yumi_o` out `num_clients_p`: per-client command consumed.
- `client_io_resp_o` out `cce_mem_msg_width_lp`: response message, broadcast to all clients.
- `client_io_resp_v_o` out `num_clients_p`: response valid, one-hot on the owner.
- `client_io_resp_ready_i` in `num_clients_p`: per-client response ready.
- `io_cmd_o` out `cce_mem_msg_width_lp`: command to the endpoint.
- `io_cmd_v_o` out 1: command valid.
- `io_cmd_yumi_i` in 1: endpoint consumed the command.
- `io_resp_i` in `cce_mem_msg_width_lp`: endpoint response.
- `io_resp_v_i` in 1: response valid.
- `io_resp_ready_o` out 1: arbiter accepts the response.
- `busy_o` out 1: a transaction is in flight (state ≠ `e_idle`).
- `owner_o` out `lg_clients_lp`: current or last granted client.

## Operation
- States: `e_idle`, `e_send`, `e_resp`.
- Registers: `state_r`, `owner_r`, `rr_ptr_r`. `rr_ptr_r` is the highest-priority index.
- Pick: the first i with `client_io_cmd_v_i[i]`, scanning from `rr_ptr_r` upward with wrap modulo `num_clients_p`.
- `e_idle`:
  - If any valid, `io_cmd_o` = pick's message, `io_cmd_v_o`=1, `owner_r`<=pick.
  - `client_io_cmd_yumi_o[pick]` = `io_cmd_yumi_i`.
  - On yumi go to `e_resp`; otherwise go to `e_send`.
- `e_send`:
  - Owner is locked. `io_cmd_o` = `client_io_cmd_i[owner_r]`, `io_cmd_v_o` = `client_io_cmd_v_i[owner_r]`.
  - Other clients are ignored even if valid.
  - On `io_cmd_yumi_i` & valid go to `e_resp`.
  - If the owner drops valid (protocol violation), return to `e_idle` without updating `rr_ptr_r`.
- `e_resp`:
  - `client_io_resp_o` = `io_resp_i`.
  - `client_io_resp_v_o[owner_r]` = `io_resp_v_i`; all other bits are 0.
  - `io_resp_ready_o` = `client_io_resp_ready_i[owner_r]`.
  - On `io_resp_v_i` & `io_resp_ready_o`: `rr_ptr_r` <= (`owner_r`+1) mod `num_clients_p`, then go to `e_idle`.
- Outside `e_resp`, `io_resp_ready_o`=0 and `client_io_resp_v_o`=0. A stray response is held off, never dropped.
- At most one yumi bit is set in any cycle.

## Timing
- Reset values: `state_r`=`e_idle`, `rr_ptr_r`=0, `owner_r`=0.
  - All `_v_o`, `yumi_o` and `io_resp_ready_o` outputs are 0 during reset and in the cycle after release with no requests.
  - `busy_o`=0.
- Command path is combinational, zero added latency. A request that is valid in an idle cycle can be yumi'd in the same cycle.
- Response path is combinational, zero added latency.
- Minimum back-to-back spacing: cmd cycle, resp cycle, next cmd cycle, i.e. 2 cycles per transaction when the endpoint responds immediately.
- New requests can be granted only in `e_idle`, which is reached in the cycle after the response handshake.
- Reset asserted mid-transaction: the block returns to `e_idle` the next cycle and abandons the in-flight transaction. The endpoint must be reset together with this block.
- Fairness: a client that holds valid is granted within `num_clients_p` transactions.

## Structure
- The state enum `bp_lite_arb_state_e` belongs in `bp_me_pkg`.
- The message types come from `` `declare_bp_bedrock_mem_if ``.
- Sub-module `bp_lite_rr_picker`: combinational. Inputs are the request vector and `rr_ptr`; outputs are the one-hot grant, the encoded index and an any-valid flag.
- Target size: about 180 lines of RTL.

## Test plan
- Single client: client 1 issues uc_rd to addr 0x1000 and the endpoint yumis immediately. Required: yumi on client 1 only; the response with data 0xDEADBEEF reaches only `client_io_resp_v_o[1]`; `rr_ptr_r`=0 afterwards (with `num_clients_p`=2).
- Contention: clients 0 and 1 both valid continuously, 6 transactions. Required grant order 0,1,0,1,0,1.
- Endpoint backpressure: `io_cmd_yumi_i` held low 5 cycles while client 1 raises valid. Required: owner stays 0 and `io_cmd_o` is unchanged throughout.
- Response backpressure: owner's `client_io_resp_ready_i`=0 for 3 cycles. Required: `io_resp_ready_o`=0 for those cycles and no new grant.
- Stray response: `io_resp_v_i`=1 in `e_idle`. Required: `io_resp_ready_o`=0 and all `client_io_resp_v_o`=0.
- Reset in `e_resp`: required next state `e_idle`, `busy_o`=0, `rr_ptr_r`=0, and client 1's next request granted normally.
